// File: rtl/fp16_result_fifo_if.sv
// Handshake/data bundle between the fp16 multiplier side and the result FIFO.
// The master drives writes/reads; the slave (the FIFO) returns data, class and status.
interface fp16_result_fifo_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]   producto;
  logic          wr_en;
  logic          rd_en;
  logic [15:0]   dout;
  logic          dout_valid;
  logic          snan, qnan, inf, zero, subnormal, normal;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          ovf, udf;

  modport master (
    output producto, wr_en, rd_en,
    input  dout, dout_valid, snan, qnan, inf, zero, subnormal, normal,
    input  count, full, empty, ovf, udf
  );

  modport slave (
    input  producto, wr_en, rd_en,
    output dout, dout_valid, snan, qnan, inf, zero, subnormal, normal,
    output count, full, empty, ovf, udf
  );
endinterface

// File: rtl/fp16_result_fifo.sv
// FIFO for half-precision products; each word is classified on entry and the
// class travels with the data so the read side gets it with no extra decode.
module fp16_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  fp16_result_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // class vector order: {snan, qnan, inf, zero, subnormal, normal}
  function automatic logic [5:0] classify(input logic [15:0] x);
    logic [4:0] e;
    logic [9:0] m;
    e = x[14:10];
    m = x[9:0];
    if (e == 5'h1f) begin
      if (m == '0)     classify = 6'b001000;
      else if (m[9])   classify = 6'b010000;
      else             classify = 6'b100000;
    end else if (e == '0) begin
      classify = (m == '0) ? 6'b000100 : 6'b000010;
    end else begin
      classify = 6'b000001;
    end
  endfunction

  logic [21:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic [15:0]   dout_q;
  logic [5:0]    cls_q;
  logic          vld_q, ovf_q, udf_q;
  logic          full, empty, rd_acc, wr_acc;

  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign rd_acc = bus.rd_en & ~empty;
  // a read in the same cycle frees a slot, so a full FIFO can still take a write
  assign wr_acc = bus.wr_en & (~full | rd_acc);

  // storage needs no reset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wptr] <= {classify(bus.producto), bus.producto};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      dout_q <= '0;
      cls_q  <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      vld_q <= rd_acc;
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) begin
        rptr            <= rptr + 1'b1;
        {cls_q, dout_q} <= mem[rptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (bus.wr_en && !wr_acc) ovf_q <= 1'b1;
      if (bus.rd_en && empty)   udf_q <= 1'b1;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q;
  assign {bus.snan, bus.qnan, bus.inf, bus.zero, bus.subnormal, bus.normal} = cls_q;
  assign bus.count      = cnt;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.ovf        = ovf_q;
  assign bus.udf        = udf_q;
endmodule

// File: tb/tb_fp16_result_fifo.sv
// Directed scenarios plus randomized traffic against a queue-based FIFO model.
module tb_fp16_result_fifo;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp16_result_fifo_if #(.DEPTH(DEPTH)) bus ();
  fp16_result_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [15:0] q[$];
  logic [15:0] m_dout;
  logic [5:0]  m_cls;
  logic        m_vld, m_ovf, m_udf;

  // classification by magnitude ranges, {snan,qnan,inf,zero,subnormal,normal}
  function automatic logic [5:0] ref_class(input logic [15:0] x);
    logic [14:0] mag;
    mag = x[14:0];
    if (mag == 15'h7c00)      return 6'b001000;
    else if (mag >= 15'h7e00) return 6'b010000;
    else if (mag > 15'h7c00)  return 6'b100000;
    else if (mag == 15'h0000) return 6'b000100;
    else if (mag < 15'h0400)  return 6'b000010;
    else                      return 6'b000001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(bus.count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(bus.full),  32'(q.size() == DEPTH));
    chk({tag, ".dout"},  32'(bus.dout),  32'(m_dout));
    chk({tag, ".vld"},   32'(bus.dout_valid), 32'(m_vld));
    chk({tag, ".cls"},   32'({bus.snan, bus.qnan, bus.inf, bus.zero, bus.subnormal, bus.normal}), 32'(m_cls));
    chk({tag, ".ovf"},   32'(bus.ovf), 32'(m_ovf));
    chk({tag, ".udf"},   32'(bus.udf), 32'(m_udf));
  endtask

  // one clock: apply inputs, advance the model, compare after the edge
  task automatic step(input string tag, input logic r, input logic w, input logic [15:0] d, input logic rd);
    bit rd_ok, wr_ok;
    rst = r; bus.wr_en = w; bus.producto = d; bus.rd_en = rd;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_dout = '0; m_cls = '0; m_vld = 0; m_ovf = 0; m_udf = 0;
    end else begin
      rd_ok = rd && (q.size() > 0);
      wr_ok = w && ((q.size() < DEPTH) || rd_ok);
      m_vld = rd_ok;
      if (rd_ok) begin
        m_dout = q.pop_front();
        m_cls  = ref_class(m_dout);
      end
      if (wr_ok) q.push_back(d);
      if (w && !wr_ok) m_ovf = 1;
      if (rd && !rd_ok) m_udf = 1;
    end
    rst = 0; bus.wr_en = 0; bus.rd_en = 0;
    check_all(tag);
  endtask

  task automatic wr(input string tag, input logic [15:0] d);
    step(tag, 0, 1, d, 0);
  endtask

  task automatic rd(input string tag);
    step(tag, 0, 0, 16'h0, 1);
  endtask

  initial begin
    logic [15:0] specials [8];
    logic [15:0] v;
    specials[0] = 16'h7c00; specials[1] = 16'hfe00; specials[2] = 16'h7c01;
    specials[3] = 16'h8000; specials[4] = 16'h0001; specials[5] = 16'h83ff;
    specials[6] = 16'h7dff; specials[7] = 16'h0400;
    rst = 1; bus.wr_en = 0; bus.rd_en = 0; bus.producto = '0;
    m_dout = '0; m_cls = '0; m_vld = 0; m_ovf = 0; m_udf = 0;

    step("reset", 1, 1, 16'h1111, 1);
    step("reset2", 1, 0, 16'h0, 0);

    wr("w4600", 16'h4600);
    rd("r4600");
    chk("r4600.normal", 32'(bus.normal), 32'd1);

    wr("winf", 16'h7c00); wr("wqnan", 16'h7e00); wr("wsnan", 16'h7c01); wr("wzero", 16'h8000);
    rd("rinf"); rd("rqnan"); rd("rsnan"); rd("rzero");

    wr("f0", 16'h0001); wr("f1", 16'h3c00); wr("f2", 16'h5fd1); wr("f3", 16'h5bad);
    wr("ovf", 16'h1234);
    chk("ovf.flag", 32'(bus.ovf), 32'd1);
    step("fullrw", 0, 1, 16'habcd, 1);
    rd("d0"); rd("d1"); rd("d2"); rd("d3");
    chk("d3.last", 32'(bus.dout), 32'h0000abcd);
    rd("udf");
    chk("udf.flag", 32'(bus.udf), 32'd1);
    step("emptyrw", 0, 1, 16'h2222, 1);
    rd("emptyrw.rd");

    for (int i = 0; i < 10; i++) begin
      wr("wrapw", 16'(16'h3000 + i));
      rd("wrapr");
    end
    wr("m0", 16'h1); wr("m1", 16'h2); wr("m2", 16'h3);
    step("midrst", 1, 0, 16'h0, 0);

    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : 16'($urandom);
      step("rand", ($urandom_range(0, 60) == 0), 1'($urandom), v, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp16_result_fifo.md
FP16_RESULT_FIFO -- requirements
Module: fp16_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of FIFO entries; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port producto  input  16  IEEE-754 half-precision product from the multiplier FSM.
REQ-005 SHALL have port wr_en  input  1  write request; producto is captured when the write is accepted.
REQ-006 SHALL have port rd_en  input  1  read request.
REQ-007 SHALL have port dout  output  16  registered data of the last accepted read.
REQ-008 SHALL have port dout_valid  output  1  one-cycle pulse, high in the cycle after an accepted read.
REQ-009 SHALL have ports snan, qnan, inf, zero, subnormal, normal  output  1 each  registered class of dout.
REQ-010 SHALL have port count  output  clog2(DEPTH)+1  number of stored entries.
REQ-011 SHALL have ports full, empty  output  1 each  combinational from count (count==DEPTH, count==0).
REQ-012 SHALL have ports ovf, udf  output  1 each  sticky overflow / underflow flags.

Function
REQ-013 SHALL classify each written word at write time and store 6 class bits alongside the 16 data bits.
REQ-014 SHALL classify with exp=producto[14:10], man=producto[9:0]: exp==31 & man==0 -> inf; exp==31 & man[9]==1 -> qnan; exp==31 & man!=0 & man[9]==0 -> snan; exp==0 & man==0 -> zero; exp==0 & man!=0 -> subnormal; otherwise normal.
REQ-015 SHALL ignore the sign bit in classification.
REQ-016 SHALL keep the six class outputs one-hot whenever at least one read has been accepted since reset.
REQ-017 SHALL accept a write when wr_en=1 and (full=0 or an accepted read occurs in the same cycle).
REQ-018 SHALL accept a read when rd_en=1 and empty=0.
REQ-019 SHALL update dout and the class outputs on the clock edge that accepts the read, visible one cycle after rd_en is sampled (1-cycle read latency, no fall-through).
REQ-020 SHALL hold dout and the class outputs unchanged when no read is accepted.
REQ-021 SHALL maintain write and read pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-022 SHALL update count: +1 on write only, -1 on read only, unchanged on simultaneous accepted write and read.
REQ-023 SHALL, when full and wr_en=1 with rd_en=1, accept both; the oldest entry is read, the new entry is stored, and count stays DEPTH.
REQ-024 SHALL, when empty and both wr_en and rd_en are 1, accept only the write; dout_valid stays 0 and udf is set.
REQ-025 SHALL drop a write with wr_en=1, full=1, rd_en=0, leave contents unchanged, and set ovf.
REQ-026 SHALL ignore a read with rd_en=1 and empty=1, hold dout, and set udf.
REQ-027 SHALL keep ovf and udf set until reset.
REQ-028 SHALL preserve first-in-first-out order across pointer wrap-around.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, clear pointers, count, dout, dout_valid, all six class outputs, ovf and udf to 0; empty=1, full=0.
REQ-030 SHALL give rst priority over wr_en and rd_en in the same cycle; no write or read is accepted.
REQ-031 SHALL discard all stored entries on reset mid-operation; storage array contents need no clearing.

Verification
REQ-032 SHALL pass: after reset, write 0x4600, then read -> next cycle dout=0x4600, normal=1, dout_valid=1, count=0, empty=1.
REQ-033 SHALL pass: write 0x7C00, 0x7E00, 0x7C01, 0x8000, then read 4 times -> inf, qnan, snan, zero in that order, one class flag high each time.
REQ-034 SHALL pass: write 0x0001, 0x3C00, 0x5FD1, 0x5BAD (DEPTH=4) -> full=1; write 0x1234 -> ovf=1, count=4; then 4 reads return 0x0001 (subnormal), 0x3C00, 0x5FD1, 0x5BAD.
REQ-035 SHALL pass: read on empty -> udf=1, dout_valid=0, dout unchanged; write+read on full -> count stays 4, oldest word out, new word stored last.
REQ-036 SHALL pass: 10 write/read pairs spanning pointer wrap -> data returned in write order; rst asserted with count=3 -> next cycle count=0, empty=1, dout=0, flags=0.
